ring_osc_trim_ctrl: RTL and testbench
=====================================

Name: ring_osc_trim_ctrl

Overview:
Closed-loop frequency controller for the 13-stage trimmable ring oscillator. It runs on the oscillator's own output clock and counts oscillator cycles per period of a slow external reference. It then steps a thermometer trim code up or down until the count matches a programmable target ratio. Its trim output feeds the oscillator's 26-bit trim input directly; a bypass path lets software drive the trim word.

Parameters:
CNT_W, 8, width of the cycle counter and of the div target
TOL, 1, half-width of the in-band window, in oscillator cycles
LOCK_N, 4, consecutive in-band measurements required to assert locked
INIT_CODE, 13, thermometer code loaded at reset; range 0..26

Ports:
clk  input  1  oscillator clock (clockp[0] of the ring oscillator)
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = closed-loop tracking active
ref_in  input  1  asynchronous slow reference clock; period must be much greater than 2 clk cycles
div  input  CNT_W  target number of clk cycles per ref_in period; quasi-static
dco  input  1  1 = bypass loop, trim = ext_trim
ext_trim  input  26  software trim word used when dco=1
trim  output  26  trim word to the oscillator; registered
code  output  5  current thermometer code 0..26
locked  output  1  frequency-in-band indication

Behaviour:
Reset and clocking:
- One clock and one asynchronous, active-high reset; all flops reset on reset=1.
- Reset values: code=INIT_CODE, trim=map(INIT_CODE), locked=0, FSM=WAIT_REF, counter=0, votes cleared, lock_cnt=0.

Reference synchronisation:
- ref_in passes through a 2-flop synchronizer, then a third flop for edge detection.
- ref_rise is a 1-cycle pulse, asserted 3 clk edges after the ref_in rising edge (±1 cycle).

Trim mapping:
- Step j (j=0..25) drives bit trim[j/2] when j is even, and trim[13+(j-1)/2] when j is odd.
- map(c) sets every step j<c and clears all others, so map(0)=0 and map(26)=all ones.
- A higher code gives more delay and therefore a lower frequency.

Counter:
- Cleared to 0 on any ref_rise cycle.
- Otherwise increments by 1 per clk and saturates at 2^CNT_W-1.
- Measurement m = counter+1, sampled on a ref_rise cycle, equals the ref period in clk cycles.
- When the counter is saturated, m = 2^CNT_W-1 (treated as a normal value).

FSM:
- WAIT_REF: the first ref_rise clears the counter and moves to MEASURE; no decision is made on it.
- MEASURE: each ref_rise evaluates m.
- enable=0 forces WAIT_REF, holds code, clears votes, lock_cnt and locked.

Decision on each ref_rise in MEASURE:
- m > div+TOL → vote UP (oscillator too fast).
- m < div-TOL → vote DOWN. When div<TOL, DOWN is never produced.
- Otherwise → IN-band.
- Arithmetic is CNT_W+1 bits, with no wrap.

Code update:
- Code changes only on two consecutive same-direction votes: UP,UP → code+1; DOWN,DOWN → code-1.
- Votes are cleared after a change.
- An IN vote or an opposite vote replaces the stored vote.
- Code saturates at 0 and at 26; a saturated request is dropped, votes are still cleared.
- code and trim update on the clk edge after the ref_rise cycle (1-cycle latency).

Lock:
- An IN vote increments lock_cnt, saturating at LOCK_N.
- An UP or DOWN vote clears lock_cnt and clears locked on the same edge.
- locked=1 whenever lock_cnt==LOCK_N, registered, appearing 1 cycle after the LOCK_N-th IN decision.

Bypass:
- dco=1: trim=ext_trim, registered with 1-cycle latency. The loop keeps its state frozen (as enable=0) and locked=0.
- dco 1→0: trim returns to map(code) on the next edge. Measurement restarts from WAIT_REF.

Other boundary cases:
- Reset mid-measurement: everything returns to reset values immediately.
- A ref_rise coinciding with enable falling: enable takes priority and no decision is made.
- A div change takes effect at the next decision.

Test Plan:
- Reset with INIT_CODE=13 → trim has bits 0..6 and 13..18 set (26'h007E07F), code=13, locked=0; a reset pulse mid-run restores these asynchronously.
- div=100, TOL=1, ref period 110 clk → code increments by 1 every 2nd decision after the first; trim updates 1 cycle after ref_rise; locked stays 0.
- Ref period equal to div then held steady with div=100 → after 4 IN decisions locked=1; a single 97-cycle period drops locked on that decision edge, and code is unchanged.
- Code at 26 with period 200, div=100 → code stays 26 and trim stays all ones; at code 0 with period 50, code stays 0.
- Alternating periods 103/97 with div=100 → no code change (votes never consecutive) and locked stays 0.
- dco=1, ext_trim=26'h2AAAAAA → trim equals the value 1 cycle later and the code is frozen; dco=0 → trim=map(code), and the first ref_rise after that produces no decision.

Source files
------------

// File: rtl/ring_osc_trim_ctrl_if.sv
// ----------------------------------------------------------------------------
// ring_osc_trim_ctrl_if
// Groups the control/status signals of the ring-oscillator trim controller.
//   enable   : closed-loop tracking enable
//   ref_in   : asynchronous slow reference clock
//   div      : target oscillator cycles per reference period
//   dco      : bypass select (trim follows ext_trim)
//   ext_trim : software trim word used in bypass
//   trim     : registered trim word to the oscillator
//   code     : current thermometer code 0..26
//   locked   : frequency-in-band indication
// master = the side that drives the controls (software / bench),
// slave  = the controller itself.
// ----------------------------------------------------------------------------
interface ring_osc_trim_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             ref_in;
    logic [CNT_W-1:0] div;
    logic             dco;
    logic [25:0]      ext_trim;
    logic [25:0]      trim;
    logic [4:0]       code;
    logic             locked;

    modport master (
        output enable, ref_in, div, dco, ext_trim,
        input  trim, code, locked
    );

    modport slave (
        input  enable, ref_in, div, dco, ext_trim,
        output trim, code, locked
    );
endinterface

// File: rtl/ring_osc_trim_ctrl.sv
// ----------------------------------------------------------------------------
// ring_osc_trim_ctrl
// Closed-loop frequency controller for the 13-stage trimmable ring oscillator.
// Runs on the oscillator clock, counts clk cycles per ref_in period and steps
// a thermometer trim code until the count sits within div +/- TOL.
// Ports:
//   clk   : oscillator clock
//   reset : asynchronous, active-high reset
//   bus   : ring_osc_trim_ctrl_if.slave (enable, ref_in, div, dco, ext_trim
//           in; trim, code, locked out)
// ----------------------------------------------------------------------------
module ring_osc_trim_ctrl #(
    parameter int CNT_W     = 8,
    parameter int TOL       = 1,
    parameter int LOCK_N    = 4,
    parameter int INIT_CODE = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    ring_osc_trim_ctrl_if.slave  bus
);

    localparam int               LW       = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   ONE_X    = (CNT_W+1)'(1);
    localparam logic [CNT_W:0]   TOL_X    = (CNT_W+1)'(TOL);
    localparam logic [LW-1:0]    LOCK_MAX = LW'(LOCK_N);
    localparam logic [4:0]       CODE_MAX = 5'd26;
    localparam logic [4:0]       CODE_RST = 5'(INIT_CODE);

    typedef enum logic {WAIT_REF, MEASURE} state_e;
    typedef enum logic [1:0] {V_NONE, V_UP, V_DN, V_IN} vote_e;

    // Step j drives trim[j/2] (even j) or trim[13+(j-1)/2] (odd j), so the
    // two halves of the trim word fill alternately as the code grows.
    function automatic logic [25:0] therm_map(input logic [4:0] c);
        logic [25:0] t;
        t = '0;
        for (int j = 0; j < 26; j++) begin
            if (j < int'(c)) begin
                if ((j % 2) == 0) t[j/2] = 1'b1;
                else              t[13 + (j-1)/2] = 1'b1;
            end
        end
        return t;
    endfunction

    function automatic logic [4:0] code_inc(input logic [4:0] c);
        return (c >= CODE_MAX) ? c : c + 5'd1;
    endfunction

    function automatic logic [4:0] code_dec(input logic [4:0] c);
        return (c == 5'd0) ? c : c - 5'd1;
    endfunction

    function automatic logic [LW-1:0] lock_inc(input logic [LW-1:0] l);
        return (l == LOCK_MAX) ? l : l + LW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Reference synchroniser and rising-edge detect
    // ------------------------------------------------------------------
    logic ref_s1_q, ref_s2_q, ref_s3_q;
    logic ref_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_s1_q <= 1'b0;
            ref_s2_q <= 1'b0;
            ref_s3_q <= 1'b0;
        end else begin
            ref_s1_q <= bus.ref_in;
            ref_s2_q <= ref_s1_q;
            ref_s3_q <= ref_s2_q;
        end
    end

    assign ref_rise = ref_s2_q & ~ref_s3_q;

    // ------------------------------------------------------------------
    // Period counter (saturating) and measurement
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   meas;
    logic [CNT_W:0]   div_x;
    logic [CNT_W:0]   hi_lim;
    logic [CNT_W:0]   lo_lim;
    logic             is_up;
    logic             is_dn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (ref_rise) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // A saturated counter reports the ceiling value rather than ceiling+1.
    assign meas   = (cnt_q == CNT_MAX) ? {1'b0, cnt_q} : {1'b0, cnt_q} + ONE_X;
    assign div_x  = {1'b0, bus.div};
    assign hi_lim = div_x + TOL_X;
    assign lo_lim = div_x - TOL_X;
    assign is_up  = (meas > hi_lim);
    // Lower bound is only meaningful when div >= TOL; otherwise no DOWN.
    assign is_dn  = (div_x >= TOL_X) && (meas < lo_lim);

    // ------------------------------------------------------------------
    // Control FSM, vote / code / lock update
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    vote_e         vote_q, vote_d;
    logic [4:0]    code_q, code_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          locked_q, locked_d;
    logic [25:0]   trim_q, trim_d;
    logic          active;

    assign active = bus.enable & ~bus.dco;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= WAIT_REF;
            vote_q   <= V_NONE;
            code_q   <= CODE_RST;
            lock_q   <= '0;
            locked_q <= 1'b0;
            trim_q   <= therm_map(CODE_RST);
        end else begin
            state_q  <= state_d;
            vote_q   <= vote_d;
            code_q   <= code_d;
            lock_q   <= lock_d;
            locked_q <= locked_d;
            trim_q   <= trim_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vote_d  = vote_q;
        code_d  = code_q;
        lock_d  = lock_q;

        if (!active) begin
            // Disabled or bypassed: freeze code, forget history.
            state_d = WAIT_REF;
            vote_d  = V_NONE;
            lock_d  = '0;
        end else begin
            case (state_q)
                WAIT_REF: begin
                    if (ref_rise) state_d = MEASURE;
                end
                MEASURE: begin
                    if (ref_rise) begin
                        if (is_up) begin
                            lock_d = '0;
                            if (vote_q == V_UP) begin
                                code_d = code_inc(code_q);
                                vote_d = V_NONE;
                            end else begin
                                vote_d = V_UP;
                            end
                        end else if (is_dn) begin
                            lock_d = '0;
                            if (vote_q == V_DN) begin
                                code_d = code_dec(code_q);
                                vote_d = V_NONE;
                            end else begin
                                vote_d = V_DN;
                            end
                        end else begin
                            vote_d = V_IN;
                            lock_d = lock_inc(lock_q);
                        end
                    end
                end
                default: state_d = WAIT_REF;
            endcase
        end

        locked_d = active && (lock_d == LOCK_MAX);
        trim_d   = bus.dco ? bus.ext_trim : therm_map(code_d);
    end

    assign bus.trim   = trim_q;
    assign bus.code   = code_q;
    assign bus.locked = locked_q;

endmodule

// File: tb/tb_ring_osc_trim_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ring_osc_trim_ctrl
// Randomised and directed stimulus for ring_osc_trim_ctrl, checked every
// cycle against a period-level behavioural model, plus literal expectations.
// ----------------------------------------------------------------------------
module tb_ring_osc_trim_ctrl;

    localparam int CNT_W     = 8;
    localparam int TOL       = 1;
    localparam int LOCK_N    = 4;
    localparam int INIT_CODE = 13;
    localparam int SAT       = (1 << CNT_W) - 1;

    logic clk;
    logic reset;

    ring_osc_trim_ctrl_if #(.CNT_W(CNT_W)) bus ();

    ring_osc_trim_ctrl #(
        .CNT_W    (CNT_W),
        .TOL      (TOL),
        .LOCK_N   (LOCK_N),
        .INIT_CODE(INIT_CODE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference thermometer map: ceil(c/2) bits fill the low half,
    // floor(c/2) bits fill the upper half starting at bit 13.
    function automatic logic [25:0] ref_map(input int c);
        logic [25:0] t;
        t = '0;
        for (int k = 0; k < (c + 1) / 2; k++) t[k] = 1'b1;
        for (int k = 0; k < c / 2; k++)       t[13 + k] = 1'b1;
        return t;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: tracks reference rises by edge number, derives
    // the period directly and applies the vote/code/lock rules.
    // ------------------------------------------------------------------
    int          mcode, mvote, mlock, edge_n, last_rise;
    bit          mwait, mlocked;
    logic [25:0] mtrim;
    bit          h1, h2, h3;

    always @(posedge clk) begin
        bit rise, act_en, up, dn;
        int m, dv;
        if (reset) begin
            mcode = INIT_CODE; mvote = 0; mlock = 0; mwait = 1;
            mlocked = 0; mtrim = ref_map(INIT_CODE);
            h1 = 0; h2 = 0; h3 = 0;
        end else begin
            edge_n++;
            // Rise seen at ref_in sample n-2 (low at n-3) is acted on at edge n.
            rise   = h2 && !h3;
            act_en = bus.enable && !bus.dco;
            m = 0;
            if (rise) begin
                m = edge_n - last_rise;
                if (m > SAT) m = SAT;
                last_rise = edge_n;
            end
            if (!act_en) begin
                mwait = 1; mvote = 0; mlock = 0;
            end else if (mwait) begin
                if (rise) mwait = 0;
            end else if (rise) begin
                dv = int'(bus.div);
                up = (m > dv + TOL);
                dn = (dv >= TOL) && (m < dv - TOL);
                if (up) begin
                    mlock = 0;
                    if (mvote == 1) begin
                        if (mcode < 26) mcode++;
                        mvote = 0;
                    end else mvote = 1;
                end else if (dn) begin
                    mlock = 0;
                    if (mvote == 2) begin
                        if (mcode > 0) mcode--;
                        mvote = 0;
                    end else mvote = 2;
                end else begin
                    mvote = 3;
                    if (mlock < LOCK_N) mlock++;
                end
            end
            mlocked = act_en && (mlock == LOCK_N);
            mtrim   = bus.dco ? bus.ext_trim : ref_map(mcode);
            h3 = h2; h2 = h1; h1 = bus.ref_in;
        end
    end

    // One compare process, every cycle outside reset.
    always @(negedge clk) begin
        if (!reset) begin
            chk("trim",   32'(bus.trim),   32'(mtrim));
            chk("code",   32'(bus.code),   32'(mcode));
            chk("locked", 32'(bus.locked), 32'(mlocked));
        end
    end

    // Drives one reference period of P clk cycles starting with a rise;
    // called and returning on a negative edge.
    task automatic ref_period(input int p);
        bus.ref_in = 1'b1;
        repeat (p / 2) @(negedge clk);
        bus.ref_in = 1'b0;
        repeat (p - p / 2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_trim",   32'(bus.trim),   32'h007E07F);
        chk("rst_code",   32'(bus.code),   32'd13);
        chk("rst_locked", 32'(bus.locked), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        edge_n = 0; last_rise = 0;
        reset = 1'b1;
        bus.enable = 1'b0; bus.ref_in = 1'b0; bus.div = 8'd100;
        bus.dco = 1'b0; bus.ext_trim = '0;
        #2;
        chk("rst_trim",   32'(bus.trim),   32'h007E07F);
        chk("rst_code",   32'(bus.code),   32'd13);
        chk("rst_locked", 32'(bus.locked), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bus.enable = 1'b1;
        @(negedge clk);

        // Too slow a count target: period 110 vs div 100 -> code climbs.
        repeat (10) ref_period(110);
        chk("up_code",   32'(bus.code),   32'd17);
        chk("up_locked", 32'(bus.locked), 32'd0);

        // In-band periods until locked, then one short period.
        repeat (6) ref_period(100);
        chk("lock_code",   32'(bus.code),   32'd18);
        chk("lock_locked", 32'(bus.locked), 32'd1);
        ref_period(97);
        ref_period(100);
        chk("drop_locked", 32'(bus.locked), 32'd0);
        chk("drop_code",   32'(bus.code),   32'd18);
        repeat (4) ref_period(100);

        // Saturation at both ends.
        repeat (30) ref_period(200);
        chk("sat_hi_code", 32'(bus.code), 32'd26);
        chk("sat_hi_trim", 32'(bus.trim), 32'h3FFFFFF);
        repeat (60) ref_period(50);
        chk("sat_lo_code", 32'(bus.code), 32'd0);
        chk("sat_lo_trim", 32'(bus.trim), 32'h0);

        // Alternating votes never step the code.
        repeat (12) begin
            ref_period(103);
            ref_period(97);
        end
        chk("alt_code", 32'(bus.code), 32'd0);

        // Bypass.
        bus.dco = 1'b1; bus.ext_trim = 26'h2AAAAAA;
        @(negedge clk);
        chk("dco_trim", 32'(bus.trim), 32'h2AAAAAA);
        chk("dco_code", 32'(bus.code), 32'd0);
        repeat (3) begin
            bus.ext_trim = 26'($urandom);
            ref_period(110);
        end
        bus.dco = 1'b0;
        @(negedge clk);
        chk("undco_trim", 32'(bus.trim), 32'h0);
        repeat (4) ref_period(120);

        // Randomised traffic.
        for (int it = 0; it < 60; it++) begin
            int p;
            bus.div    = 8'($urandom_range(97, 103));
            bus.enable = ($urandom_range(0, 9) != 0);
            bus.dco    = ($urandom_range(0, 9) == 0);
            bus.ext_trim = 26'($urandom);
            p = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 300)
                                             : $urandom_range(94, 106);
            if ($urandom_range(0, 19) == 0) begin
                ref_period(p / 2);
                pulse_reset();
            end else begin
                ref_period(p);
            end
        end
        bus.dco = 1'b0; bus.enable = 1'b1; bus.div = 8'd100;
        repeat (8) ref_period(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
